// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: one-access-per-cycle arbiter sharing a single-port
// synchronous RAM between the CPU core and the host loader port.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cpu_*              CPU request/grant/read-return channel
//   host_*             host loader request/grant/read-return channel
//   host_lock          host asks for exclusive ownership of the RAM
//   locked             high while the host owns the RAM (CPU stalls)
//   ram_*              steering to the RAM; ram_q valid one cycle after rden
module ram_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,

  output logic          locked,

  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    LOCK_PEND = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            cpu_rd_q, cpu_rd_d;
  logic            host_rd_q, host_rd_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;
  logic            host_win;
  logic            starved;

  assign starved = (starve_q == LIMIT);

  // Grant selection and lock FSM next state.
  always_comb begin
    state_d  = state_q;
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    host_win = 1'b0;
    if (!rst) begin
      unique case (state_q)
        NORMAL: begin
          // CPU has priority until the host has waited STARVE_LIMIT
          // cycles in a row; then the host is forced through once.
          host_win = host_req & (~cpu_req | starved);
          cpu_gnt  = cpu_req & ~host_win;
          host_gnt = host_win;
          if (host_lock) begin
            state_d = LOCK_PEND;
          end
        end
        LOCK_PEND: begin
          // Dead cycle: lets a CPU read granted last cycle return
          // before the host takes the RAM.
          state_d = LOCKED;
        end
        LOCKED: begin
          host_gnt = host_req;
          if (!host_lock) begin
            state_d = NORMAL;
          end
        end
        default: begin
          state_d = NORMAL;
        end
      endcase
    end
  end

  // Host starvation counter, only meaningful while arbitrating.
  always_comb begin
    starve_d = '0;
    if (state_q == NORMAL && host_req && !host_gnt) begin
      if (starved) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  // RAM steering; idle bus is driven to zero.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_rden  = ~cpu_we;
      ram_wren  = cpu_we;
    end else if (host_gnt) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_rden  = ~host_we;
      ram_wren  = host_we;
    end
  end

  // Owner tags for the read in flight and held read data.
  always_comb begin
    cpu_rd_d     = cpu_gnt & ~cpu_we;
    host_rd_d    = host_gnt & ~host_we;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    if (cpu_rd_q) begin
      cpu_rdata_d = ram_q;
    end
    if (host_rd_q) begin
      host_rdata_d = ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      starve_q     <= '0;
      cpu_rd_q     <= 1'b0;
      host_rd_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cpu_rd_q     <= cpu_rd_d;
      host_rd_q    <= host_rd_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Returning data is presented straight from the RAM in the
  // result cycle, then held until the next result for that side.
  assign cpu_rvalid  = cpu_rd_q;
  assign host_rvalid = host_rd_q;
  assign cpu_rdata   = cpu_rd_q  ? ram_q : cpu_rdata_q;
  assign host_rdata  = host_rd_q ? ram_q : host_rdata_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed self-checking bench for ram_port_arbiter
// with a behavioural synchronous RAM attached to the ram_* port.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       host_req, host_we, host_lock;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       locked;
  logic [7:0] ram_addr, ram_wdata, ram_q;
  logic       ram_rden, ram_wren;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .locked(locked),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // RAM model; known contents are reapplied on reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h05] <= 8'hA3;
      mem[8'h01] <= 8'h5A;
      mem[8'h02] <= 8'hC3;
      ram_q      <= 8'h00;
    end else begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      if (ram_rden) ram_q <= mem[ram_addr];
    end
  end

  task automatic idle();
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 8'h00;
    cpu_wdata  = 8'h00;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 8'h00;
    host_wdata = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_req  = 1'b1;
    host_req = 1'b1;
    #1;
    checks++;
    if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt cpu=%b host=%b want 0/0",
               cpu_gnt, host_gnt);
    end
    checks++;
    if (ram_rden !== 1'b0 || ram_wren !== 1'b0 ||
        ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_ram rden=%b wren=%b a=%h d=%h want 0",
               ram_rden, ram_wren, ram_addr, ram_wdata);
    end
    checks++;
    if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 ||
        locked !== 1'b0 || cpu_rdata !== 8'h00 ||
        host_rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_out rv=%b/%b lk=%b rd=%h/%h want 0",
               cpu_rvalid, host_rvalid, locked,
               cpu_rdata, host_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 8'h05;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 ||
        ram_rden !== 1'b1 || ram_wren !== 1'b0 ||
        ram_addr !== 8'h05) begin
      failures++;
      $display("FAIL cpu_rd_gnt g=%b hg=%b rden=%b a=%h want 1 0 1 05",
               cpu_gnt, host_gnt, ram_rden, ram_addr);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA3 ||
        host_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_rd_ret rv=%b d=%h hrv=%b want 1 a3 0",
               cpu_rvalid, cpu_rdata, host_rvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA3 ||
        ram_rden !== 1'b0 || ram_addr !== 8'h00) begin
      failures++;
      $display("FAIL cpu_rd_hold rv=%b d=%h rden=%b a=%h want 0 a3 0 00",
               cpu_rvalid, cpu_rdata, ram_rden, ram_addr);
    end
  endtask

  task automatic test_starve();
    logic exp_h;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_addr  = 8'h01;
      host_req  = 1'b1;
      host_addr = 8'h02;
      #1;
      exp_h = ((i % 5) == 4);
      checks++;
      if (cpu_gnt !== ~exp_h || host_gnt !== exp_h) begin
        failures++;
        $display("FAIL starve_c%0d cpu=%b host=%b want %b %b",
                 i, cpu_gnt, host_gnt, ~exp_h, exp_h);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_host_write();
    @(negedge clk);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h10;
    host_wdata = 8'h3C;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0 ||
        ram_wren !== 1'b1 || ram_rden !== 1'b0 ||
        ram_wdata !== 8'h3C || ram_addr !== 8'h10) begin
      failures++;
      $display("FAIL host_wr g=%b wren=%b rden=%b a=%h d=%h",
               host_gnt, ram_wren, ram_rden, ram_addr, ram_wdata);
    end
    @(negedge clk);
    host_we    = 1'b0;
    host_wdata = 8'h00;
    #1;
    checks++;
    if (host_rvalid !== 1'b0 || host_gnt !== 1'b1 ||
        ram_rden !== 1'b1) begin
      failures++;
      $display("FAIL host_rd_gnt rv=%b g=%b rden=%b want 0 1 1",
               host_rvalid, host_gnt, ram_rden);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h3C ||
        cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL host_rd_ret rv=%b d=%h crv=%b want 1 3c 0",
               host_rvalid, host_rdata, cpu_rvalid);
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_addr  = 8'h05;
    host_lock = 1'b1;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_req g=%b lk=%b want 1 0", cpu_gnt, locked);
    end
    @(negedge clk);
    host_req  = 1'b1;
    host_addr = 8'h10;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA3) begin
      failures++;
      $display("FAIL lock_pend_ret rv=%b d=%h want 1 a3",
               cpu_rvalid, cpu_rdata);
    end
    checks++;
    if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || locked !== 1'b0 ||
        ram_rden !== 1'b0) begin
      failures++;
      $display("FAIL lock_pend_gnt c=%b h=%b lk=%b rden=%b want 0",
               cpu_gnt, host_gnt, locked, ram_rden);
    end
    @(negedge clk);
    #1;
    checks++;
    if (locked !== 1'b1 || host_gnt !== 1'b1 || cpu_gnt !== 1'b0 ||
        ram_addr !== 8'h10) begin
      failures++;
      $display("FAIL locked_gnt lk=%b h=%b c=%b a=%h want 1 1 0 10",
               locked, host_gnt, cpu_gnt, ram_addr);
    end
    @(negedge clk);
    host_req  = 1'b0;
    host_lock = 1'b0;
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h3C ||
        locked !== 1'b1 || cpu_gnt !== 1'b0) begin
      failures++;
      $display("FAIL locked_ret rv=%b d=%h lk=%b c=%b want 1 3c 1 0",
               host_rvalid, host_rdata, locked, cpu_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL unlock lk=%b c=%b want 0 1", locked, cpu_gnt);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    logic       prev_cpu;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      if ((i % 2) == 0) begin
        cpu_req  = 1'b1;
        cpu_addr = 8'h01;
      end else begin
        host_req  = 1'b1;
        host_addr = 8'h02;
      end
      #1;
      checks++;
      if (cpu_gnt !== ((i % 2) == 0) || host_gnt !== ((i % 2) == 1)) begin
        failures++;
        $display("FAIL b2b_gnt%0d c=%b h=%b", i, cpu_gnt, host_gnt);
      end
      if (i > 0) begin
        prev_cpu = ((i % 2) == 1);
        checks++;
        if (prev_cpu &&
            (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A ||
             host_rvalid !== 1'b0)) begin
          failures++;
          $display("FAIL b2b_ret%0d crv=%b d=%h hrv=%b want 1 5a 0",
                   i, cpu_rvalid, cpu_rdata, host_rvalid);
        end else if (!prev_cpu &&
            (host_rvalid !== 1'b1 || host_rdata !== 8'hC3 ||
             cpu_rvalid !== 1'b0)) begin
          failures++;
          $display("FAIL b2b_ret%0d hrv=%b d=%h crv=%b want 1 c3 0",
                   i, host_rvalid, host_rdata, cpu_rvalid);
        end
      end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'hC3 ||
        cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A) begin
      failures++;
      $display("FAIL b2b_last hrv=%b hd=%h crv=%b cd=%h",
               host_rvalid, host_rdata, cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_reset_discard();
    @(negedge clk);
    host_lock = 1'b1;
    @(negedge clk);
    @(negedge clk);
    host_req  = 1'b1;
    host_addr = 8'h10;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL rstd_gnt g=%b lk=%b want 1 1", host_gnt, locked);
    end
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b1;
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h3C ||
        host_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rstd_pre rv=%b d=%h g=%b/%b want 1 3c 0 0",
               host_rvalid, host_rdata, cpu_gnt, host_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (host_rvalid !== 1'b0 || host_rdata !== 8'h00 ||
        cpu_rdata !== 8'h00 || locked !== 1'b0 ||
        ram_rden !== 1'b0 || ram_addr !== 8'h00) begin
      failures++;
      $display("FAIL rstd_post rv=%b hd=%h cd=%h lk=%b rden=%b a=%h",
               host_rvalid, host_rdata, cpu_rdata, locked,
               ram_rden, ram_addr);
    end
    @(negedge clk);
    rst       = 1'b0;
    host_lock = 1'b0;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL rstd_normal c=%b h=%b lk=%b want 1 0 0",
               cpu_gnt, host_gnt, locked);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst       = 1'b1;
    host_lock = 1'b0;
    idle();
    test_reset();
    test_cpu_read();
    test_starve();
    test_host_write();
    test_lock();
    test_back_to_back();
    test_reset_discard();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port synchronous program/data RAM between the CPU core (fetch/exec accesses) and a host loader port used to load programs and inspect memory. Arbitrates one access per cycle, steers address, data and read/write enables to the RAM, and routes one-cycle-latency read data back to the winning requester. Provides a host lock mode that fences the CPU out entirely during program download.

Parameters:
AW, 8, address width (RAM depth 2^AW)
DW, 8, data width
STARVE_LIMIT, 4, consecutive cycles host may be denied while requesting before it is forced a grant (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU requests an access this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid (registered, cycle after read grant)
cpu_rdata  out  DW  read data to CPU
host_req  in  1  host requests an access
host_we  in  1  1 = write, 0 = read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_lock  in  1  request exclusive RAM ownership for host
host_gnt  out  1  host access accepted this cycle (combinational)
host_rvalid  out  1  host_rdata valid (registered)
host_rdata  out  DW  read data to host
locked  out  1  high in LOCKED state (CPU must stall; tie to stage halt)
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rden  out  1  RAM read enable
ram_wren  out  1  RAM write enable
ram_q  in  DW  RAM read data, valid cycle after ram_rden

Behaviour:
- Reset: FSM=NORMAL; starve counter=0; cpu_rvalid=host_rvalid=locked=0; rdata outputs 0; no grants while rst high; ram_rden=ram_wren=0, ram_addr=ram_wdata=0.
- At most one grant per cycle; cpu_gnt & host_gnt never both 1.
- FSM states NORMAL, LOCK_PEND, LOCKED.
- NORMAL grant rule: CPU wins if cpu_req, unless host_req and starve count == STARVE_LIMIT, then host wins. Host wins if host_req and no CPU req.
- Starve counter: +1 (saturating at STARVE_LIMIT) each NORMAL cycle with host_req and !host_gnt; cleared on host_gnt or !host_req.
- NORMAL -> LOCK_PEND when host_lock=1. LOCK_PEND: no CPU grants; host not granted; exactly one cycle so any CPU read granted the previous cycle returns its rvalid; then -> LOCKED.
- LOCKED: locked=1; host_gnt=host_req; cpu_gnt=0. host_lock=0 -> NORMAL next cycle (locked drops same edge). host_lock re-asserted in NORMAL re-enters LOCK_PEND.
- RAM steering: granted requester's addr/wdata driven; ram_rden = gnt & !we; ram_wren = gnt & we. No grant: enables 0, addr/wdata hold 0.
- Read return: registered owner tag of the read granted in cycle N; in cycle N+1 the owner's rvalid=1 and rdata=ram_q; other side rvalid=0, rdata holds last value. Writes produce no rvalid.
- Back-to-back reads by either side: one result per cycle, order preserved, no bubbles.
- Read granted in same cycle rst asserts: result discarded, rvalid=0 after reset.
- Address wrap: none performed; addresses pass through unchanged.
- Synthesizable, no latches; all case defaults assigned.

Test Plan:
- Reset, then cpu_req read addr 0x05 (RAM[5]=0xA3) -> cpu_gnt=1 same cycle, ram_rden=1, ram_addr=0x05; next cycle cpu_rvalid=1, cpu_rdata=0xA3, host_rvalid=0.
- cpu_req and host_req held continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, host granted on 5th, pattern repeats every 5 cycles; never simultaneous grants.
- Host writes 0x3C to 0x10 with no CPU req -> host_gnt=1, ram_wren=1, ram_wdata=0x3C; subsequent host read of 0x10 returns 0x3C with host_rvalid one cycle after grant.
- CPU read granted, host_lock raised same cycle -> next cycle LOCK_PEND, cpu_rvalid=1 with correct data, no grants; following cycle locked=1, host accesses granted, cpu_req ignored; drop host_lock -> locked=0 next cycle, CPU granted again.
- Alternating CPU read 0x01 / host read 0x02 every cycle -> rvalid returns on correct side each cycle with matching data, zero bubbles.
- rst asserted one cycle after a host read grant -> host_rvalid=0, all outputs at reset values, FSM NORMAL.
